// File: rtl/add_cla_serial_ctrl_pkg.sv
// Shared constants and state type for the serial carry-lookahead add/sub
// controller.
package add_cla_serial_ctrl_pkg;

  // Bits processed per cycle by the lookahead slice.
  localparam int NIBBLE = 4;

  // State encodings, kept as constants so other blocks can decode them.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/add_cla_serial_ctrl_cla4.sv
// 4-bit carry-lookahead adder slice. All carries are formed directly from
// the bit generate/propagate terms, so there is no ripple inside the nibble.
module add_cla_serial_ctrl_cla4 (
  input  logic [3:0] iA,
  input  logic [3:0] iB,
  input  logic       iC,
  output logic [3:0] oS,
  output logic       oC,
  output logic       oG,
  output logic       oP
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = iA & iB;
  assign p = iA ^ iB;

  assign c[0] = iC;
  assign c[1] = g[0] | (p[0] & iC);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & iC);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & iC);

  // Group terms let a wider tree chain slices; the carry out reuses them.
  assign oG = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign oP = &p;
  assign oC = oG | (oP & iC);

  assign oS = p ^ c;

endmodule

// File: rtl/add_cla_serial_ctrl.sv
// WIDTH-bit add/subtract built by running one 4-bit lookahead slice over
// WIDTH/4 cycles, least-significant nibble first, with the carry registered
// between nibbles. Valid/ready handshakes on operand and result sides.
module add_cla_serial_ctrl
  import add_cla_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iSub,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oS,
  output logic             oC,
  output logic             oZero
);

  localparam int NSLICE = WIDTH / NIBBLE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NSLICE - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_cy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             z_q;

  logic [NIBBLE-1:0] slice_sum;
  logic              slice_co;
  logic              slice_g;
  logic              slice_p;
  logic              unused_gp;
  logic              accept;
  logic              last;
  logic [WIDTH-1:0]  s_shift;

  add_cla_serial_ctrl_cla4 u_slice (
    .iA (r_a[NIBBLE-1:0]),
    .iB (r_b[NIBBLE-1:0]),
    .iC (r_cy),
    .oS (slice_sum),
    .oC (slice_co),
    .oG (slice_g),
    .oP (slice_p)
  );

  // Group generate/propagate are not needed when the slice is time-shared.
  assign unused_gp = slice_g ^ slice_p;

  assign accept  = iValid && (state == IDLE);
  assign last    = (state == RUN) && (cnt == CNT_LAST);
  assign s_shift = {slice_sum, r_s[WIDTH-1:NIBBLE]};

  // State register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      state <= state_nxt;
    end
  end

  // Next-state decode; handshakes move the sequencer between phases.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (iValid)            state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST)   state_nxt = DONE;
      DONE:    if (iReady)            state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Operand capture and one nibble of arithmetic per RUN cycle.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_s  <= '0;
      r_cy <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
      r_a  <= iA;
      r_b  <= iB ^ {WIDTH{iSub}};
      r_cy <= iSub;
      cnt  <= '0;
    end else if (state == RUN) begin
      r_s  <= s_shift;
      r_a  <= r_a >> NIBBLE;
      r_b  <= r_b >> NIBBLE;
      r_cy <= slice_co;
      if (!last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Result registers load on the final nibble and then hold, so the outputs
  // stay stable under backpressure and keep their value after retirement.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s_q <= '0;
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else if (last) begin
      s_q <= s_shift;
      c_q <= slice_co;
      z_q <= (s_shift == '0);
    end
  end

  assign oReady = (state == IDLE);
  assign oValid = (state == DONE);
  assign oS     = s_q;
  assign oC     = c_q;
  assign oZero  = z_q;

endmodule

// File: tb/tb_add_cla_serial_ctrl.sv
// Directed bench for add_cla_serial_ctrl: a vector table of add/sub cases
// plus hand-written backpressure, reset-in-flight and back-to-back sequences.
module tb_add_cla_serial_ctrl;

  localparam int W = 24;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready_dut;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         cons_ready;
  logic [W-1:0] s;
  logic         c;
  logic         z;

  int n_tests = 0;
  int n_fail  = 0;

  add_cla_serial_ctrl #(.WIDTH(W)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .iValid (in_valid),
    .oReady (out_ready_dut),
    .iA     (a),
    .iB     (b),
    .iSub   (sub),
    .oValid (out_valid),
    .iReady (cons_ready),
    .oS     (s),
    .oC     (c),
    .oZero  (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         z;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a negedge: wait for oReady, present operands for one
  // edge, then confirm the controller has left IDLE.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tsub, input string name);
    int n = 0;
    while (!out_ready_dut && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " ready_wait"}, 32'(n < 20), 32'd1);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    sub      = tsub;
    @(negedge clk);
    in_valid = 1'b0;
    check({name, " accepted"}, 32'(out_ready_dut), 32'd0);
  endtask

  // Counts edges from the handshake edge until oValid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic retire();
    cons_ready = 1'b1;
    @(negedge clk);
    cons_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [W-1:0] es,
                              input logic ec, input logic ez);
    check({name, " oS"},    32'(s), 32'(es));
    check({name, " oC"},    32'(c), 32'(ec));
    check({name, " oZero"}, 32'(z), 32'(ez));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W-1:0] hold_s;

    vecs[0]  = '{24'h000001, 24'h000002, 1'b0, 24'h000003, 1'b0, 1'b0};
    vecs[1]  = '{24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1, 1'b1};
    vecs[2]  = '{24'h000005, 24'h000003, 1'b1, 24'h000002, 1'b1, 1'b0};
    vecs[3]  = '{24'h000003, 24'h000005, 1'b1, 24'hFFFFFE, 1'b0, 1'b0};
    vecs[4]  = '{24'h000000, 24'h000000, 1'b1, 24'h000000, 1'b1, 1'b1};
    vecs[5]  = '{24'h123456, 24'h654321, 1'b0, 24'h777777, 1'b0, 1'b0};
    vecs[6]  = '{24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b1, 1'b1};
    vecs[7]  = '{24'h0000AA, 24'h000055, 1'b0, 24'h0000FF, 1'b0, 1'b0};
    vecs[8]  = '{24'h00000F, 24'h000001, 1'b0, 24'h000010, 1'b0, 1'b0};
    vecs[9]  = '{24'hABCDEF, 24'hABCDEF, 1'b1, 24'h000000, 1'b1, 1'b1};
    vecs[10] = '{24'h000000, 24'h000001, 1'b1, 24'hFFFFFF, 1'b0, 1'b0};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    cons_ready = 1'b0;
    a          = '0;
    b          = '0;
    sub        = 1'b0;
    repeat (2) @(negedge clk);

    check("reset oReady", 32'(out_ready_dut), 32'd1);
    check("reset oValid", 32'(out_valid), 32'd0);
    check_result("reset", 24'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven add/subtract with latency check.
    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub, nm);
      wait_valid(lat);
      check({nm, " latency"}, 32'(lat), 32'd6);
      check_result(nm, vecs[i].s, vecs[i].c, vecs[i].z);
      retire();
      check({nm, " oValid drop"}, 32'(out_valid), 32'd0);
      check({nm, " hold oS"}, 32'(s), 32'(vecs[i].s));
    end

    // Backpressure: result holds while a new request waits.
    start_op(24'h111111, 24'h222222, 1'b0, "bp op1");
    wait_valid(lat);
    check("bp op1 latency", 32'(lat), 32'd6);
    in_valid = 1'b1;
    a        = 24'h000001;
    b        = 24'h000001;
    sub      = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp hold%0d oValid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp hold%0d oReady", k), 32'(out_ready_dut), 32'd0);
      check_result($sformatf("bp hold%0d", k), 24'h333333, 1'b0, 1'b0);
      @(negedge clk);
    end
    cons_ready = 1'b1;
    @(negedge clk);
    cons_ready = 1'b0;
    check("bp idle oReady", 32'(out_ready_dut), 32'd1);
    check("bp idle oValid", 32'(out_valid), 32'd0);
    check("bp idle oS", 32'(s), 32'h333333);
    @(negedge clk);
    check("bp op2 accepted", 32'(out_ready_dut), 32'd0);
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp op2 latency", 32'(lat), 32'd6);
    check_result("bp op2", 24'h000002, 1'b0, 1'b0);
    retire();

    // Reset while the sequencer is mid-RUN.
    start_op(24'h123456, 24'h654321, 1'b0, "rst op");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst oValid", 32'(out_valid), 32'd0);
    check("rst oReady", 32'(out_ready_dut), 32'd1);
    check_result("rst", 24'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(24'h00000F, 24'h000001, 1'b0, "post rst");
    wait_valid(lat);
    check("post rst latency", 32'(lat), 32'd6);
    check_result("post rst", 24'h000010, 1'b0, 1'b0);
    retire();

    // Back-to-back with iValid and iReady held high.
    in_valid   = 1'b1;
    cons_ready = 1'b1;
    a          = 24'hAAAAAA;
    b          = 24'h555555;
    sub        = 1'b0;
    @(negedge clk);
    check("b2b op1 accepted", 32'(out_ready_dut), 32'd0);
    a = 24'h800000;
    b = 24'h800000;
    wait_valid(lat);
    check("b2b op1 latency", 32'(lat), 32'd6);
    check_result("b2b op1", 24'hFFFFFF, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b idle oReady", 32'(out_ready_dut), 32'd1);
    check("b2b idle oValid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("b2b op2 accepted", 32'(out_ready_dut), 32'd0);
    in_valid = 1'b0;
    hold_s   = s;
    check("b2b run holds oS", 32'(hold_s), 32'hFFFFFF);
    wait_valid(lat);
    check("b2b op2 latency", 32'(lat), 32'd6);
    check_result("b2b op2", 24'h000000, 1'b1, 1'b1);
    @(negedge clk);
    cons_ready = 1'b0;
    check("b2b end oValid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
